// File: rtl/fproc_req.sv
// Core-side fproc request initiator: issues one request, waits for the reply and holds the result.
// Optional request timeout and orphan-reply tracking are enabled by defining FPROC_TIMEOUT_EN.
module fproc_req #(
    parameter int unsigned ID_WIDTH       = 8,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [ID_WIDTH-1:0]   req_id,
    output logic                  req_ready,
    output logic                  result_valid,
    output logic [DATA_WIDTH-1:0] result_data,
    output logic                  result_err,
    input  logic                  result_ack,
    output logic                  busy,
    output logic                  fproc_enable,
    output logic [ID_WIDTH-1:0]   fproc_id,
    input  logic                  fproc_ready,
    input  logic [DATA_WIDTH-1:0] fproc_data,
    output logic [15:0]           timeout_count
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StDone,
        StOrphan
    } state_e;

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

`ifdef FPROC_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            orphan_q, orphan_d;
    logic [15:0]     tcnt_q, tcnt_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        data_d  = data_q;
`ifdef FPROC_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
        orphan_d = orphan_q;
        tcnt_d   = tcnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    id_d    = req_id;
                    state_d = StIssue;
                end
            end
            StIssue: begin
`ifdef FPROC_TIMEOUT_EN
                cnt_d = '0;
`endif
                state_d = StWait;
            end
            StWait: begin
                // A reply in the final counted cycle still beats the timeout.
                if (fproc_ready) begin
                    data_d  = fproc_data;
`ifdef FPROC_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = StDone;
                end
`ifdef FPROC_TIMEOUT_EN
                else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    data_d   = '0;
                    err_d    = 1'b1;
                    orphan_d = 1'b1;
                    if (tcnt_q != 16'hFFFF) begin
                        tcnt_d = tcnt_q + 16'd1;
                    end
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`endif
            end
            StDone: begin
`ifdef FPROC_TIMEOUT_EN
                // A late reply here only retires the orphan; the held result is untouched.
                if (fproc_ready) begin
                    orphan_d = 1'b0;
                end
                if (result_ack) begin
                    state_d = (orphan_q && !fproc_ready) ? StOrphan : StIdle;
                end
`else
                if (result_ack) begin
                    state_d = StIdle;
                end
`endif
            end
            StOrphan: begin
`ifdef FPROC_TIMEOUT_EN
                if (fproc_ready) begin
                    orphan_d = 1'b0;
                    state_d  = StIdle;
                end
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            id_q    <= '0;
            data_q  <= '0;
`ifdef FPROC_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
            orphan_q <= 1'b0;
            tcnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            data_q  <= data_d;
`ifdef FPROC_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            orphan_q <= orphan_d;
            tcnt_q   <= tcnt_d;
`endif
        end
    end

    assign req_ready    = (state_q == StIdle);
    assign busy         = (state_q != StIdle);
    assign fproc_enable = (state_q == StIssue);
    assign result_valid = (state_q == StDone);
    assign fproc_id     = id_q;
    assign result_data  = data_q;

`ifdef FPROC_TIMEOUT_EN
    assign result_err    = err_q;
    assign timeout_count = tcnt_q;
`else
    assign result_err    = 1'b0;
    assign timeout_count = 16'd0;
`endif

endmodule

// File: tb/tb_fproc_req.sv
// Scoreboard bench for fproc_req: a driver plays core and responder, a monitor checks results.
// Works with or without FPROC_TIMEOUT_EN; the reference model follows the same define.
module tb_fproc_req;

    localparam int unsigned N = 8;
`ifdef FPROC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [7:0]  req_id = 8'h0;
    logic        req_ready;
    logic        result_valid;
    logic [31:0] result_data;
    logic        result_err;
    logic        result_ack = 1'b0;
    logic        busy;
    logic        fproc_enable;
    logic [7:0]  fproc_id;
    logic        fproc_ready = 1'b0;
    logic [31:0] fproc_data = 32'h0;
    logic [15:0] timeout_count;

    fproc_req #(
        .ID_WIDTH      (8),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(N)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_id       (req_id),
        .req_ready    (req_ready),
        .result_valid (result_valid),
        .result_data  (result_data),
        .result_err   (result_err),
        .result_ack   (result_ack),
        .busy         (busy),
        .fproc_enable (fproc_enable),
        .fproc_id     (fproc_id),
        .fproc_ready  (fproc_ready),
        .fproc_data   (fproc_data),
        .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] id;
        int         at;
    } en_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          at;
        logic [15:0] tc;
    } res_t;

    en_t  en_q[$];
    res_t res_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic [15:0] model_tc = 16'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: matches each request strobe and each new result against the scoreboard.
    initial begin
        logic rv_prev;
        en_t  e;
        res_t r;
        rv_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                rv_prev = 1'b0;
            end else begin
                if (fproc_enable) begin
                    if (en_q.size() == 0) begin
                        check("enable_spurious", {63'b0, fproc_enable}, 64'd0);
                    end else begin
                        e = en_q.pop_front();
                        check("enable_id", {56'b0, fproc_id}, {56'b0, e.id});
                        check("enable_cycle", 64'(cyc), 64'(e.at));
                    end
                end
                if (result_valid && !rv_prev) begin
                    if (res_q.size() == 0) begin
                        check("result_spurious", {63'b0, result_valid}, 64'd0);
                    end else begin
                        r = res_q.pop_front();
                        check("result_data", {32'b0, result_data}, {32'b0, r.data});
                        check("result_err", {63'b0, result_err}, {63'b0, r.err});
                        check("result_cycle", 64'(cyc), 64'(r.at));
                        check("timeout_count", {48'b0, timeout_count}, {48'b0, r.tc});
                    end
                end
                rv_prev = result_valid;
            end
        end
    end

    // Called at a negedge with the DUT expected idle. d: reply period offset from the accept
    // period (>=2); a reply later than the wait window becomes a timeout when enabled.
    task automatic run_txn(input logic [7:0] id, input int d, input logic [31:0] dat,
                           input int ack_wait, input int late_mode, input int late_gap);
        int   guard;
        int   acc, r_p, rr, ack_p, late_p, idle_p;
        bit   to;
        res_t r;
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_wait", {63'b0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_id    = id;
        acc       = cyc + 1;
        en_q.push_back('{id: id, at: acc});

        to = TO_EN && (d > int'(N) + 1);
        if (to) begin
            r_p = -1;
            rr  = acc + 1 + int'(N);
        end else begin
            r_p = acc - 1 + d;
            rr  = r_p + 1;
        end
        ack_p  = rr + ack_wait;
        late_p = -1;
        if (to) begin
            late_p = (late_mode == 0 && ack_wait > 0) ? rr + (late_gap % ack_wait)
                                                      : ack_p + 1 + late_gap;
            if (model_tc != 16'hFFFF) model_tc = model_tc + 16'd1;
        end
        idle_p = (to && late_p > ack_p) ? late_p + 1 : ack_p + 1;
        r.data = to ? 32'h0 : dat;
        r.err  = to;
        r.at   = rr;
        r.tc   = model_tc;
        res_q.push_back(r);

        @(negedge clk);
        req_valid = 1'b0;
        req_id    = 8'($urandom);
        while (cyc < idle_p) begin
            // The strobe during the issue cycle must be ignored.
            fproc_ready = (cyc == r_p) || (cyc == late_p) || (cyc == acc);
            fproc_data  = (cyc == r_p) ? dat : $urandom;
            result_ack  = (cyc == ack_p);
            if (cyc < rr || cyc > ack_p) begin
                check("status_busy", {61'b0, busy, req_ready, result_valid}, 64'b100);
            end else begin
                check("status_done", {61'b0, busy, req_ready, result_valid}, 64'b101);
                check("held_data", {31'b0, result_err, result_data}, {31'b0, r.err, r.data});
            end
            @(negedge clk);
        end
        fproc_ready = 1'b0;
        result_ack  = 1'b0;
        check("status_idle", {61'b0, busy, req_ready, result_valid}, 64'b010);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: cycle %0d exceeded budget", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        repeat (3) @(negedge clk);
        check("reset_status", {59'b0, fproc_enable, busy, result_valid, result_err, req_ready},
              64'b00001);
        reset = 1'b0;
        @(negedge clk);

        run_txn(8'h05, 2, 32'h1, 1, 0, 0);

        // Abandon a request mid-wait with reset.
        req_valid = 1'b1;
        req_id    = 8'hA5;
        acc       = cyc + 1;
        en_q.push_back('{id: 8'hA5, at: acc});
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_status", {59'b0, fproc_enable, busy, result_valid, result_err, req_ready},
              64'b00001);
        check("rst_id", {56'b0, fproc_id}, 64'd0);
        check("rst_data", {32'b0, result_data}, 64'd0);
        check("rst_tcount", {48'b0, timeout_count}, 64'd0);
        model_tc = 16'd0;
        reset = 1'b0;
        @(negedge clk);

        run_txn(8'h3C, 51, $urandom, 0, 1, 0);
        run_txn(8'h11, int'(N) + 1, $urandom, 2, 1, 0);
        run_txn(8'h12, 100, $urandom, 0, 1, 3);
        run_txn(8'h13, 100, $urandom, 3, 0, 1);
        run_txn(8'h14, int'(N) + 2, $urandom, 1, 1, 0);
        run_txn(8'h15, 5000, $urandom, 1, 1, 2);
        for (int i = 0; i < 40; i++) begin
            run_txn(8'($urandom), int'($urandom_range(2, 14)), $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 4)));
        end

        repeat (2) @(negedge clk);
        check("en_queue_empty", 64'(en_q.size()), 64'd0);
        check("res_queue_empty", 64'(res_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
